sar_search: RTL and testbench
=============================

# sar_search

Successive-approximation search engine that drives the probe side of the team's 4-bit magnitude comparator and consumes its `greater`/`equal`/`lesser` flags to recover an unknown target value applied on the comparator's other input. It sits upstream of the comparator instance. It issues one probe per step, samples the flags after a programmable settle time, and reports the recovered value, a found flag, a step count and a protocol-error flag.

## Interface
Parameters:
- `WIDTH`, default 4: probe/target width in bits.
- `SETTLE`, default 0: extra cycles between a probe change and flag sampling. Use 0 for a combinational comparator.

Ports:
- `clk`: input, 1 bit. Single clock; all logic on its rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `start`: input, 1 bit. Request a search. Honoured only while idle.
- `greater`: input, 1 bit. Comparator flag: target > probe.
- `equal`: input, 1 bit. Comparator flag: target == probe.
- `lesser`: input, 1 bit. Comparator flag: target < probe.
- `probe`: output, WIDTH bits. Value driven to the comparator's `b` input.
- `busy`: output, 1 bit. High from the cycle after `start` is accepted until `done`.
- `done`: output, 1 bit. One-cycle pulse when a search ends.
- `result`: output, WIDTH bits. Recovered target. Valid from `done` until the next accepted `start`.
- `found`: output, 1 bit. Set when `equal` was observed on some probe.
- `err`: output, 1 bit. Set when the flags were not exactly one-hot at a sample point.
- `steps`: output, $clog2(WIDTH+2) bits. Number of probes sampled in the last search.

## Operation
- The state machine has five states: IDLE, PROBE, SETTLE, VERIFY, DONE.
- **IDLE:** `probe`=0 and `busy`=0. When `start`=1, clear `result`, `found`, `err` and `steps`, set bit index i=WIDTH-1, and go to PROBE.
- **PROBE:** drive `probe` = `result` | (1<<i). If SETTLE=0, sample the flags this cycle. Otherwise go to SETTLE, count SETTLE cycles, then sample. Each sample increments `steps`.
- **Sample rules in PROBE:**
  - Flags not one-hot: set `err`=1 and go to DONE.
  - `equal`: set `result`=probe and `found`=1, then go to DONE (early exit).
  - `greater`: keep the bit, i.e. `result` |= (1<<i).
  - `lesser`: leave the bit cleared.
  - If i>0: decrement i and stay in PROBE.
  - If i==0: go to VERIFY.
- **VERIFY:** drive `probe`=`result`, apply the same settle rule, then sample.
  - `equal`: set `found`=1.
  - Any other valid flag: set `err`=1, because the comparator is inconsistent.
  - Non-one-hot flags: set `err`=1.
  - Then go to DONE.
- **DONE:** assert `done` for one cycle, drop `busy`, return to IDLE. `probe` returns to 0.
- `start` while `busy` is ignored. `start` coinciding with `done` is ignored; only `start` sampled in IDLE is accepted.
- Width rules:
  - Probes never exceed 2^WIDTH-1.
  - Maximum `steps` is WIDTH+1; the extra step is VERIFY, needed only when `equal` is never hit, e.g. target 0.

## Timing
- Reset values: `probe`=0, `busy`=0, `done`=0, `result`=0, `found`=0, `err`=0, `steps`=0, state=IDLE.
- `rst` mid-search aborts on the next edge and forces all of the reset values. No `done` pulse is produced for the aborted search.
- `start` is accepted at edge 0.
- With SETTLE=0:
  - The first probe (2^(WIDTH-1)) is visible after edge 0.
  - One step per cycle.
  - `done` is high in the cycle after the final sample.
  - Latency from `start` to `done` is `steps`+1 cycles.
- With SETTLE>0: each step takes 1+SETTLE cycles, and `probe` is held constant across the settle window.
- `result`, `found`, `err` and `steps` are stable from the `done` cycle until the next accepted `start`.

## Structure
- Package `sar_search_pkg`:
  - state enum {IDLE, PROBE, SETTLE, VERIFY, DONE};
  - function `onehot3(g,e,l)`.
- One sub-module, `settle_counter`: loadable down-counter with parameter SETTLE.
  - Loaded on every probe change.
  - Asserts `expired` when the count reaches zero.
  - With SETTLE=0, `expired` is tied high.
- Main block: FSM, result/bit-index registers, step counter.

## Test plan
The bench instantiates the team's comparator, with `a`=target and `b`=`probe`. WIDTH=4, SETTLE=0 unless noted.
1. Target 7 → probes 8,4,6,7; `equal` on the fourth; `result`=7, `found`=1, `steps`=4, `err`=0, `done` 5 cycles after `start`.
2. Target 8 → single probe 8 equal; `steps`=1; `done` 2 cycles after `start`.
3. Target 0 → probes 8,4,2,1 (all lesser), then VERIFY probe 0 equal; `result`=0, `found`=1, `steps`=5. Target 15 → probes 8,12,14,15; `steps`=4.
4. Fault injection: force `greater`=`equal`=1 on the second probe → `err`=1, `found`=0, `done` next cycle. Tie all flags to 0 → `err` on the first sample.
5. SETTLE=2, target 5: each probe is held 3 cycles; probes 8,4,6,5; `steps`=4; `done` 13 cycles after `start`.
6. Assert `rst` during the third probe → all outputs zero next cycle, no `done` pulse. A `start` issued while `busy` has no effect on the probe sequence. A fresh `start` after reset completes normally.

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared state encoding and flag check for the successive-approximation search engine.
// No logic of its own; latency and backpressure do not apply.
package sar_search_pkg;

  typedef enum logic [2:0] {IDLE, PROBE, SETTLE, VERIFY, DONE} state_t;

  // Comparator flags are only trusted when exactly one of them is set.
  function automatic logic onehot3(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Probe/flag/result bundle between the search engine (slave) and its driver/comparator side (master).
// Wires only: no latency, no backpressure.
interface sar_search_if #(parameter int WIDTH = 4);
  localparam int SW = $clog2(WIDTH + 2);

  logic             start;
  logic             greater;
  logic             equal;
  logic             lesser;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;
  logic [SW-1:0]    steps;

  modport master (
    output start, greater, equal, lesser,
    input  probe, busy, done, result, found, err, steps
  );

  modport slave (
    input  start, greater, equal, lesser,
    output probe, busy, done, result, found, err, steps
  );
endinterface

// File: rtl/sar_search_settle_counter.sv
// Settle timer: reloads whenever load is high, then counts down and flags expired at zero.
// expired is high SETTLE cycles after load drops; with SETTLE=0 it is constantly high. No backpressure.
module settle_counter #(
  parameter int SETTLE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  generate
    if (SETTLE == 0) begin : g_none
      logic unused_in;
      assign unused_in = ^{clk, rst, load};
      assign expired   = 1'b1;
    end else begin : g_cnt
      localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
      logic [CW-1:0] cnt;

      // Reload with SETTLE-1 so the zero state is reached after exactly SETTLE cycles.
      always_ff @(posedge clk) begin
        if (rst || load) begin
          cnt <= CW'(SETTLE - 1);
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end

      assign expired = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/sar_search.sv
// SAR search: recovers a comparator target MSB-first with an optional consistency VERIFY probe.
// start-to-done = steps*(1+SETTLE)+1 cycles; start is ignored unless idle, no other backpressure.
module sar_search #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.slave  bus
);
  import sar_search_pkg::state_t;
  import sar_search_pkg::onehot3;
  import sar_search_pkg::IDLE;
  import sar_search_pkg::PROBE;
  import sar_search_pkg::VERIFY;
  import sar_search_pkg::DONE;

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             vfy;
  logic             expired;
  logic             smp;
  logic             valid;
  logic [WIDTH-1:0] cur_bit;
  logic [WIDTH-1:0] nxt_bit;
  logic [WIDTH-1:0] kept;

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (state != sar_search_pkg::SETTLE),
    .expired (expired)
  );

  always_comb begin
    cur_bit = WIDTH'(1) << idx;
    nxt_bit = WIDTH'(1) << (idx - 1'b1);
    kept    = bus.result | (bus.greater ? cur_bit : '0);
    valid   = onehot3(bus.greater, bus.equal, bus.lesser);
    // Without a settle window the flags are read in the same cycle the probe is shown.
    if (SETTLE == 0) begin
      smp = (state == PROBE) || (state == VERIFY);
    end else begin
      smp = (state == sar_search_pkg::SETTLE) && expired;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      vfy        <= 1'b0;
      bus.probe  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.found  <= 1'b0;
      bus.err    <= 1'b0;
      bus.steps  <= '0;
    end else if (smp) begin
      bus.steps <= bus.steps + 1'b1;
      if (!valid) begin
        bus.err <= 1'b1;
        state   <= DONE;
      end else if (vfy) begin
        // A completed bit walk must land exactly on the target.
        if (bus.equal) bus.found <= 1'b1;
        else           bus.err   <= 1'b1;
        state <= DONE;
      end else if (bus.equal) begin
        bus.result <= bus.probe;
        bus.found  <= 1'b1;
        state      <= DONE;
      end else begin
        bus.result <= kept;
        if (idx != '0) begin
          idx       <= idx - 1'b1;
          bus.probe <= kept | nxt_bit;
          state     <= PROBE;
        end else begin
          bus.probe <= kept;
          vfy       <= 1'b1;
          state     <= VERIFY;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.result <= '0;
            bus.found  <= 1'b0;
            bus.err    <= 1'b0;
            bus.steps  <= '0;
            idx        <= IW'(WIDTH - 1);
            vfy        <= 1'b0;
            bus.probe  <= WIDTH'(1) << (WIDTH - 1);
            bus.busy   <= 1'b1;
            state      <= PROBE;
          end
        end
        PROBE, VERIFY: state <= sar_search_pkg::SETTLE;
        DONE: begin
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          bus.probe <= '0;
          state     <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench: behavioural 4-bit comparator in front of two engines (SETTLE=0 and SETTLE=2),
// with flag fault injection, reset abort and start-while-busy cases.
module tb_sar_search;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(4)) bus0 ();
  sar_search_if #(.WIDTH(4)) bus1 ();

  sar_search #(.WIDTH(4), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sar_search #(.WIDTH(4), .SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [3:0] tgt0 = 4'd0;
  logic [3:0] tgt1 = 4'd0;
  int         fmode = 0;
  int         sel = 0;

  // Comparator model: a = target, b = probe; fmode 1 corrupts probe 4, fmode 2 kills all flags.
  always_comb begin
    bus0.greater = tgt0 > bus0.probe;
    bus0.equal   = tgt0 == bus0.probe;
    bus0.lesser  = tgt0 < bus0.probe;
    if (fmode == 1 && bus0.probe == 4'd4) begin
      bus0.greater = 1'b1;
      bus0.equal   = 1'b1;
      bus0.lesser  = 1'b0;
    end else if (fmode == 2) begin
      bus0.greater = 1'b0;
      bus0.equal   = 1'b0;
      bus0.lesser  = 1'b0;
    end
    bus1.greater = tgt1 > bus1.probe;
    bus1.equal   = tgt1 == bus1.probe;
    bus1.lesser  = tgt1 < bus1.probe;
  end

  logic       m_done, m_busy, m_found, m_err;
  logic [3:0] m_probe, m_result;
  logic [2:0] m_steps;

  always_comb begin
    m_done   = (sel == 0) ? bus0.done   : bus1.done;
    m_busy   = (sel == 0) ? bus0.busy   : bus1.busy;
    m_found  = (sel == 0) ? bus0.found  : bus1.found;
    m_err    = (sel == 0) ? bus0.err    : bus1.err;
    m_probe  = (sel == 0) ? bus0.probe  : bus1.probe;
    m_result = (sel == 0) ? bus0.result : bus1.result;
    m_steps  = (sel == 0) ? bus0.steps  : bus1.steps;
  end

  int         n_assert = 0;
  int         n_fail = 0;
  int         lat;
  logic [3:0] pr [0:39];
  logic [3:0] d_res, d_probe;
  logic [2:0] d_steps;
  logic       d_found, d_err, d_busy, d_done2, saw_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, log the probe seen in every cycle after the accept edge, snapshot outputs at done.
  task automatic run(input int s, input logic [3:0] tgt, input int xs);
    sel = s;
    @(negedge clk);
    if (s == 0) begin tgt0 = tgt; bus0.start = 1'b1; end
    else        begin tgt1 = tgt; bus1.start = 1'b1; end
    @(negedge clk);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (s == 0) bus0.start = (c == xs);
      else        bus1.start = (c == xs);
      if (m_done) begin
        lat = c;
        break;
      end
      pr[c] = m_probe;
      @(negedge clk);
    end
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    d_res   = m_result;
    d_found = m_found;
    d_err   = m_err;
    d_steps = m_steps;
    d_busy  = m_busy;
    d_probe = m_probe;
    @(negedge clk);
    d_done2 = m_done;
  endtask

  task automatic chk_end(input string nm, input int elat, input logic [3:0] eres,
                         input logic efound, input logic eerr, input logic [2:0] esteps);
    chk({nm, "_lat"},   lat,     elat);
    chk({nm, "_res"},   d_res,   eres);
    chk({nm, "_found"}, d_found, efound);
    chk({nm, "_err"},   d_err,   eerr);
    chk({nm, "_steps"}, d_steps, esteps);
    chk({nm, "_busy"},  d_busy,  1'b0);
    chk({nm, "_probe"}, d_probe, 4'd0);
    chk({nm, "_pulse"}, d_done2, 1'b0);
  endtask

  task automatic chk_seq(input string nm, input logic [31:0] seq, input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hold; j++) begin
        chk($sformatf("%s_p%0d", nm, k * hold + j), pr[k * hold + j], seq[31 - 4 * k -: 4]);
      end
    end
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_probe",  bus0.probe,  4'd0);
    chk("rst_busy",   bus0.busy,   1'b0);
    chk("rst_done",   bus0.done,   1'b0);
    chk("rst_result", bus0.result, 4'd0);
    chk("rst_found",  bus0.found,  1'b0);
    chk("rst_err",    bus0.err,    1'b0);
    chk("rst_steps",  bus0.steps,  3'd0);
    chk("rst1_busy",  bus1.busy,   1'b0);
    chk("rst1_probe", bus1.probe,  4'd0);
    rst = 1'b0;

    run(0, 4'd7, -1);
    chk_end("t7", 5, 4'd7, 1'b1, 1'b0, 3'd4);
    chk_seq("t7", 32'h8467_0000, 4, 1);

    run(0, 4'd8, -1);
    chk_end("t8", 2, 4'd8, 1'b1, 1'b0, 3'd1);
    chk_seq("t8", 32'h8000_0000, 1, 1);

    run(0, 4'd0, -1);
    chk_end("t0", 6, 4'd0, 1'b1, 1'b0, 3'd5);
    chk_seq("t0", 32'h8421_0000, 5, 1);

    run(0, 4'd15, -1);
    chk_end("t15", 5, 4'd15, 1'b1, 1'b0, 3'd4);
    chk_seq("t15", 32'h8CEF_0000, 4, 1);

    run(0, 4'd10, -1);
    chk_end("t10", 4, 4'd10, 1'b1, 1'b0, 3'd3);
    chk_seq("t10", 32'h8CA0_0000, 3, 1);

    fmode = 1;
    run(0, 4'd3, -1);
    chk_end("fge", 3, 4'd0, 1'b0, 1'b1, 3'd2);
    chk_seq("fge", 32'h8400_0000, 2, 1);

    fmode = 2;
    run(0, 4'd9, -1);
    chk_end("fzero", 2, 4'd0, 1'b0, 1'b1, 3'd1);
    fmode = 0;

    run(1, 4'd5, -1);
    chk_end("s2t5", 13, 4'd5, 1'b1, 1'b0, 3'd4);
    chk_seq("s2t5", 32'h8465_0000, 4, 3);

    // Reset while the third probe is on the bus.
    sel = 0;
    @(negedge clk);
    tgt0 = 4'd7;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_p3", bus0.probe, 4'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_probe",  bus0.probe,  4'd0);
    chk("abort_busy",   bus0.busy,   1'b0);
    chk("abort_done",   bus0.done,   1'b0);
    chk("abort_result", bus0.result, 4'd0);
    chk("abort_found",  bus0.found,  1'b0);
    chk("abort_err",    bus0.err,    1'b0);
    chk("abort_steps",  bus0.steps,  3'd0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done = saw_done | bus0.done;
    end
    chk("abort_nodone", saw_done, 1'b0);

    run(0, 4'd7, 2);
    chk_end("busy_st", 5, 4'd7, 1'b1, 1'b0, 3'd4);
    chk_seq("busy_st", 32'h8467_0000, 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
